shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Autonomous controller for the 4-bit shift register datapath. It generates the 8-bit control word that would otherwise come from the switches: {op[1:0], dinR, data[3:0], dinL}.
- On a start pulse it loads a seed value.
- It then issues one shift or rotate step every TICK_DIV clocks, for a programmed number of steps or until stopped.
- The register output is fed back so that rotate modes can be formed.
- Sits between the board inputs and the shifter; the seven-segment path is unchanged.

Parameters:
TICK_DIV, 25000000, clocks per step period (one step per second at 50 MHz); legal range 1 to 2^32-1.
CNT_W, 4, width of the steps and step_cnt fields.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request; mode, seed and steps are latched on acceptance
stop  in  1  terminates a running sequence
mode  in  2  00 shift right zero-fill, 01 shift left zero-fill, 10 rotate right, 11 rotate left (bounce, see Optional Feature)
seed  in  4  value loaded into the register at sequence start
steps  in  CNT_W  number of steps; 0 means continuous
reg_q  in  4  current shift-register output (feedback)
ctrl  out  8  control word to the shifter: [7:6] op, [5] dinR, [4:1] data, [0] dinL
busy  out  1  high from start acceptance until the done cycle, inclusive
done  out  1  one-cycle pulse at sequence end
step_cnt  out  CNT_W  number of steps issued in the current or last sequence

Behaviour:
- Op encoding:
  - HOLD = 00
  - SHR = 01: bit3 <- dinR, bits shift toward bit0
  - SHL = 10: bit0 <- dinL
  - LOAD = 11: register <- data
- Reset, asynchronous: state IDLE; ctrl = 0 (HOLD, zero data); busy = 0; done = 0; step_cnt = 0; tick counter = 0; direction = left.
- All outputs are registered. The shifter samples ctrl on the edge after ctrl is driven, so every non-HOLD op is held for exactly one cycle.
- States:
  - IDLE: ctrl = HOLD. start=1 latches the inputs, clears step_cnt and goes to LOAD. stop is ignored.
  - LOAD, one cycle: ctrl = {LOAD, 0, seed, 0}. Go to WAIT, or to STEP if TICK_DIV = 1.
  - WAIT: ctrl = HOLD for TICK_DIV-1 cycles, then go to STEP.
  - STEP, one cycle:
    - mode 00: {SHR, dinR=0}
    - mode 01: {SHL, dinL=0}
    - mode 10: {SHR, dinR=reg_q[0]}
    - mode 11: {SHL, dinL=reg_q[3]}
    - step_cnt increments, wrapping at 2^CNT_W.
    - If steps != 0 and the new step_cnt == steps, go to DONE; otherwise go to WAIT, or stay in STEP if TICK_DIV = 1.
  - DONE, one cycle: done = 1, ctrl = HOLD. Go to IDLE.
- Step period is exactly TICK_DIV clocks. The first step issues TICK_DIV clocks after the LOAD cycle.
- Boundary cases:
  - start while busy: ignored.
  - stop while in LOAD or WAIT: no further steps; go to DONE next cycle.
  - stop during a STEP cycle: that step still issues, then go to DONE.
  - stop and a terminal step in the same cycle: single DONE.
  - steps = 0: continuous; step_cnt wraps; only stop ends the sequence.
  - reg_q is sampled in the STEP cycle only; it is stable because the preceding cycles are HOLD or LOAD.
  - Inputs changing mid-sequence have no effect because they are latched at start.

Optional Feature:
SEQ_BOUNCE_EN
- Defined: mode 11 is bounce ("scanner").
  - Direction register, starting left, updated in STEP using pre-step reg_q:
    - if direction = left and reg_q[3] = 1, issue SHR and set direction = right;
    - if direction = right and reg_q[0] = 1, issue SHL and set direction = left;
    - otherwise issue the current direction.
  - Zero-fill in both directions.
  - Direction resets to left at each start.
- Not defined: mode 11 is rotate left as above; the direction register is absent.

Decomposition:
- Package shift_seq_pkg:
  - op constants SEQ_OP_HOLD/SHR/SHL/LOAD
  - mode constants SEQ_MODE_SHR/SHL/ROR/ROL
  - state encoding IDLE/LOAD/WAIT/STEP/DONE
  - ctrl field bit positions
- Sub-module seq_tick_gen: a TICK_DIV prescaler with a clear input and a one-cycle terminal pulse. The FSM clears it in LOAD and STEP.

Test Plan:
All cases use TICK_DIV = 4 and a 4-bit shift-register model driven by ctrl, with reg_q connected back.
- mode 01, seed 0001, steps 3, start: LOAD on cycle 1; reg_q = 0010, 0100, 1000 at 4-cycle spacing; done pulses once; step_cnt = 3; busy falls after done.
- mode 10, seed 1001, steps 4: reg_q = 1100, 0110, 0011, 1001; done.
- mode 00, seed 1111, steps 0, stop after 6 steps: reg_q reaches 0000 and stays; step_cnt wraps from 15 to 0 in a longer run; stop mid-WAIT gives done next cycle with no extra step.
- Assert rst_n low during WAIT: ctrl = 00000000 and busy = 0 the same cycle; after release, start is needed again. start asserted while busy has no effect.
- TICK_DIV = 1, mode 01, steps 2: LOAD, STEP, STEP, DONE on consecutive cycles.
- With SEQ_BOUNCE_EN, mode 11, seed 0001, steps 6: reg_q = 0010, 0100, 1000, 0100, 0010, 0001.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// ----------------------------------------------------------------------------
// shift_seq_pkg
// Shared definitions for the shift-register sequencer:
//   - shifter op codes carried in ctrl[7:6]
//   - sequencer mode codes (the 2-bit mode input)
//   - FSM state encoding
//   - bit positions of the fields inside the 8-bit control word
//   - helpers to build a control word and to predict the shifter's next value
// No ports (package).
// ----------------------------------------------------------------------------
package shift_seq_pkg;

  // Shifter op codes
  localparam logic [1:0] SEQ_OP_HOLD = 2'b00;
  localparam logic [1:0] SEQ_OP_SHR  = 2'b01;  // bit3 <- dinR, shift toward bit0
  localparam logic [1:0] SEQ_OP_SHL  = 2'b10;  // bit0 <- dinL, shift toward bit3
  localparam logic [1:0] SEQ_OP_LOAD = 2'b11;  // register <- data

  // Sequencer modes
  localparam logic [1:0] SEQ_MODE_SHR = 2'b00;  // shift right, zero fill
  localparam logic [1:0] SEQ_MODE_SHL = 2'b01;  // shift left, zero fill
  localparam logic [1:0] SEQ_MODE_ROR = 2'b10;  // rotate right
  localparam logic [1:0] SEQ_MODE_ROL = 2'b11;  // rotate left, or bounce

  // Control word layout: {op[1:0], dinR, data[3:0], dinL}
  localparam int CTRL_OP_MSB   = 7;
  localparam int CTRL_OP_LSB   = 6;
  localparam int CTRL_DINR     = 5;
  localparam int CTRL_DATA_MSB = 4;
  localparam int CTRL_DATA_LSB = 1;
  localparam int CTRL_DINL     = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_STEP = 3'd3,
    ST_DONE = 3'd4
  } seq_state_e;

  // Assemble a control word from its fields.
  function automatic logic [7:0] seq_ctrl(input logic [1:0] op, input logic dinr,
                                          input logic [3:0] data, input logic dinl);
    logic [7:0] w;
    w = 8'd0;
    w[CTRL_OP_MSB:CTRL_OP_LSB]     = op;
    w[CTRL_DINR]                   = dinr;
    w[CTRL_DATA_MSB:CTRL_DATA_LSB] = data;
    w[CTRL_DINL]                   = dinl;
    return w;
  endfunction

  // Value the shifter will hold after it applies control word w to q.
  function automatic logic [3:0] seq_apply(input logic [7:0] w, input logic [3:0] q);
    logic [3:0] r;
    case (w[CTRL_OP_MSB:CTRL_OP_LSB])
      SEQ_OP_SHR:  r = {w[CTRL_DINR], q[3:1]};
      SEQ_OP_SHL:  r = {q[2:0], w[CTRL_DINL]};
      SEQ_OP_LOAD: r = w[CTRL_DATA_MSB:CTRL_DATA_LSB];
      default:     r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_sequencer_tick.sv
// ----------------------------------------------------------------------------
// seq_tick_gen
// Step-period prescaler. Counts clocks modulo TICK_DIV and flags the last
// clock of each period. A clear restarts the period; the clearing cycle is
// itself counted as the first clock of the new period, so a tick appears
// exactly TICK_DIV-1 cycles after the clear and the FSM sees a step period of
// exactly TICK_DIV clocks. With TICK_DIV = 1 tick is constantly high.
// Ports:
//   clk    in  1  system clock, rising edge
//   rst_n  in  1  asynchronous active-low reset (counter -> 0)
//   clear  in  1  restart the period
//   tick   out 1  high on the last clock of a period
// ----------------------------------------------------------------------------
module seq_tick_gen #(
  parameter int unsigned TICK_DIV = 32'd25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam logic [31:0] LAST    = 32'(TICK_DIV - 32'd1);
  localparam logic [31:0] RESTART = (TICK_DIV > 32'd1) ? 32'd1 : 32'd0;

  logic [31:0] cnt_r;

  // Period counter with restart on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 32'd0;
    end else if (clear) begin
      cnt_r <= RESTART;
    end else if (cnt_r >= LAST) begin
      cnt_r <= 32'd0;
    end else begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/shift_sequencer.sv
// ----------------------------------------------------------------------------
// shift_sequencer
// Autonomous controller for the 4-bit shift-register datapath. On start it
// loads a seed, then issues one shift/rotate step every TICK_DIV clocks for
// the programmed number of steps (0 = continuous) or until stop.
// Optional feature macro: SEQ_BOUNCE_EN -- when defined, mode 11 becomes a
// zero-fill "scanner" that reverses direction when a 1 reaches the end bit;
// otherwise mode 11 is rotate left.
// Ports:
//   clk       in  1      system clock, rising edge
//   rst_n     in  1      asynchronous active-low reset
//   start     in  1      start request (mode/seed/steps latched on acceptance)
//   stop      in  1      end a running sequence
//   mode      in  2      00 SHR, 01 SHL, 10 ROR, 11 ROL/bounce
//   seed      in  4      value loaded at sequence start
//   steps     in  CNT_W  step count, 0 = continuous
//   reg_q     in  4      shift-register output (feedback)
//   ctrl      out 8      {op[1:0], dinR, data[3:0], dinL}
//   busy      out 1      high from acceptance through the done cycle
//   done      out 1      one-cycle pulse at sequence end
//   step_cnt  out CNT_W  steps issued in the current/last sequence
// All outputs are registered: each output register is loaded from the value
// belonging to the state being entered, so ctrl is valid for the whole cycle
// of that state and the shifter samples it on the following edge.
// ----------------------------------------------------------------------------
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 32'd25000000,
  parameter int          CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [3:0]       seed,
  input  logic [CNT_W-1:0] steps,
  input  logic [3:0]       reg_q,
  output logic [7:0]       ctrl,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_cnt
);

  seq_state_e       state_r, state_s;
  logic [1:0]       mode_r, mode_s;
  logic [CNT_W-1:0] steps_r, steps_s;
  logic [CNT_W-1:0] step_cnt_r, step_cnt_s;
  logic [7:0]       ctrl_r, ctrl_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [7:0]       step_ctrl_s;
  logic [3:0]       cur_q_s;
  logic             tick_s;
  logic             clear_s;
`ifdef SEQ_BOUNCE_EN
  logic             dir_left_r, dir_left_s, step_dir_s;
`endif

  // The prescaler restarts its period on every LOAD and STEP cycle.
  assign clear_s = (state_r == ST_LOAD) || (state_r == ST_STEP);

  seq_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // The step word is registered on the edge where the shifter applies the
  // currently driven word, so feedback is taken from the register value
  // after that word. In the normal case ctrl_r is HOLD and this is reg_q
  // itself; it only differs for back-to-back LOAD/STEP cycles (TICK_DIV = 1).
  assign cur_q_s = seq_apply(ctrl_r, reg_q);

  // Step control word for the latched mode, plus bounce direction update.
  always_comb begin
    step_ctrl_s = seq_ctrl(SEQ_OP_HOLD, 1'b0, 4'd0, 1'b0);
`ifdef SEQ_BOUNCE_EN
    step_dir_s  = dir_left_r;
`endif
    case (mode_r)
      SEQ_MODE_SHR: step_ctrl_s = seq_ctrl(SEQ_OP_SHR, 1'b0, 4'd0, 1'b0);
      SEQ_MODE_SHL: step_ctrl_s = seq_ctrl(SEQ_OP_SHL, 1'b0, 4'd0, 1'b0);
      SEQ_MODE_ROR: step_ctrl_s = seq_ctrl(SEQ_OP_SHR, cur_q_s[0], 4'd0, 1'b0);
      SEQ_MODE_ROL: begin
`ifdef SEQ_BOUNCE_EN
        if (dir_left_r) begin
          if (cur_q_s[3]) begin
            step_ctrl_s = seq_ctrl(SEQ_OP_SHR, 1'b0, 4'd0, 1'b0);
            step_dir_s  = 1'b0;
          end else begin
            step_ctrl_s = seq_ctrl(SEQ_OP_SHL, 1'b0, 4'd0, 1'b0);
          end
        end else begin
          if (cur_q_s[0]) begin
            step_ctrl_s = seq_ctrl(SEQ_OP_SHL, 1'b0, 4'd0, 1'b0);
            step_dir_s  = 1'b1;
          end else begin
            step_ctrl_s = seq_ctrl(SEQ_OP_SHR, 1'b0, 4'd0, 1'b0);
          end
        end
`else
        step_ctrl_s = seq_ctrl(SEQ_OP_SHL, 1'b0, 4'd0, cur_q_s[3]);
`endif
      end
      default: step_ctrl_s = seq_ctrl(SEQ_OP_HOLD, 1'b0, 4'd0, 1'b0);
    endcase
  end

  // Next-state logic followed by the output values of the state being entered.
  always_comb begin
    state_s    = state_r;
    mode_s     = mode_r;
    steps_s    = steps_r;
    step_cnt_s = step_cnt_r;
    ctrl_s     = seq_ctrl(SEQ_OP_HOLD, 1'b0, 4'd0, 1'b0);
    busy_s     = 1'b1;
    done_s     = 1'b0;
`ifdef SEQ_BOUNCE_EN
    dir_left_s = dir_left_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s    = ST_LOAD;
          mode_s     = mode;
          steps_s    = steps;
          step_cnt_s = '0;
`ifdef SEQ_BOUNCE_EN
          dir_left_s = 1'b1;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          state_s = ST_DONE;
        end else if (TICK_DIV == 32'd1) begin
          state_s = ST_STEP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (stop) begin
          state_s = ST_DONE;
        end else if (tick_s) begin
          state_s = ST_STEP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_STEP: begin
        // step_cnt_r already counts the step issued in this cycle.
        if (stop || ((steps_r != '0) && (step_cnt_r == steps_r))) begin
          state_s = ST_DONE;
        end else if (TICK_DIV == 32'd1) begin
          state_s = ST_STEP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase

    case (state_s)
      ST_IDLE: busy_s = 1'b0;
      ST_LOAD: ctrl_s = seq_ctrl(SEQ_OP_LOAD, 1'b0, seed, 1'b0);
      ST_STEP: begin
        ctrl_s     = step_ctrl_s;
        step_cnt_s = step_cnt_r + CNT_W'(1);
`ifdef SEQ_BOUNCE_EN
        dir_left_s = step_dir_s;
`endif
      end
      ST_DONE: done_s = 1'b1;
      default: busy_s = 1'b1;
    endcase
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      mode_r     <= SEQ_MODE_SHR;
      steps_r    <= '0;
      step_cnt_r <= '0;
      ctrl_r     <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef SEQ_BOUNCE_EN
      dir_left_r <= 1'b1;
`endif
    end else begin
      state_r    <= state_s;
      mode_r     <= mode_s;
      steps_r    <= steps_s;
      step_cnt_r <= step_cnt_s;
      ctrl_r     <= ctrl_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
`ifdef SEQ_BOUNCE_EN
      dir_left_r <= dir_left_s;
`endif
    end
  end

  assign ctrl     = ctrl_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign step_cnt = step_cnt_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// ----------------------------------------------------------------------------
// tb_shift_sequencer
// Directed bench for shift_sequencer. Two instances: dut (TICK_DIV = 4) and
// dut1 (TICK_DIV = 1), each closing the loop through a 4-bit shift-register
// model driven by ctrl. Expected register values after every step are queued
// when a sequence is started and popped as steps appear on ctrl.
// Mode 11 expectations follow SEQ_BOUNCE_EN.
// ----------------------------------------------------------------------------
module tb_shift_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, stop;
  logic [1:0] mode;
  logic [3:0] seed, steps, reg_q;
  logic [7:0] ctrl;
  logic       busy, done;
  logic [3:0] step_cnt;

  logic       start1;
  logic [3:0] reg_q1;
  logic [7:0] ctrl1;
  logic       busy1, done1;
  logic [3:0] step_cnt1;

  shift_sequencer #(.TICK_DIV(32'd4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .seed(seed), .steps(steps), .reg_q(reg_q), .ctrl(ctrl), .busy(busy),
    .done(done), .step_cnt(step_cnt)
  );

  shift_sequencer #(.TICK_DIV(32'd1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop(1'b0), .mode(2'b01),
    .seed(4'b0001), .steps(4'd2), .reg_q(reg_q1), .ctrl(ctrl1), .busy(busy1),
    .done(done1), .step_cnt(step_cnt1)
  );

  // Shift-register datapath model for dut.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_q <= 4'd0;
    else begin
      case (ctrl[7:6])
        2'b01:   reg_q <= {ctrl[5], reg_q[3:1]};
        2'b10:   reg_q <= {reg_q[2:0], ctrl[0]};
        2'b11:   reg_q <= ctrl[4:1];
        default: reg_q <= reg_q;
      endcase
    end
  end

  // Shift-register datapath model for dut1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_q1 <= 4'd0;
    else begin
      case (ctrl1[7:6])
        2'b01:   reg_q1 <= {ctrl1[5], reg_q1[3:1]};
        2'b10:   reg_q1 <= {reg_q1[2:0], ctrl1[0]};
        2'b11:   reg_q1 <= ctrl1[4:1];
        default: reg_q1 <= reg_q1;
      endcase
    end
  end

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  logic       step_pending = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge; score the register after a step seen last cycle.
  task automatic cyc();
    logic [3:0] e;
    @(negedge clk);
    if (step_pending) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_step observed=%b expected=no_step", reg_q);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_reg_q", 32'(reg_q), 32'(e));
      end
    end
    step_pending = (ctrl[7:6] == 2'b01) || (ctrl[7:6] == 2'b10);
  endtask

  task automatic start_seq(input logic [1:0] m, input logic [3:0] s, input logic [3:0] n);
    mode  = m;
    seed  = s;
    steps = n;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("load_ctrl", 32'(ctrl), 32'({2'b11, 1'b0, s, 1'b0}));
    chk("load_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_step(input int period, input logic [3:0] cnt);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step_pending && n < 64);
    chk("step_period", 32'(n), 32'(period));
    chk("step_cnt", 32'(step_cnt), 32'(cnt));
  endtask

  task automatic wait_done(input logic [3:0] cnt);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!done && n < 64);
    chk("done_latency", 32'(n), 32'd1);
    chk("done_ctrl", 32'(ctrl), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_step_cnt", 32'(step_cnt), 32'(cnt));
    cyc();
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; start1 = 1'b0;
    mode = 2'b00; seed = 4'd0; steps = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_step_cnt", 32'(step_cnt), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Shift left zero-fill, 3 steps; a start pulse mid-run is ignored.
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    start_seq(2'b01, 4'b0001, 4'd3);
    wait_step(4, 4'd1);
    start = 1'b1; mode = 2'b10; seed = 4'hF; steps = 4'd0;
    cyc();
    start = 1'b0;
    wait_step(3, 4'd2);
    wait_step(4, 4'd3);
    wait_done(4'd3);

    // Rotate right, 4 steps.
    exp_q.push_back(4'b1100); exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0011); exp_q.push_back(4'b1001);
    start_seq(2'b10, 4'b1001, 4'd4);
    for (int i = 0; i < 4; i++) wait_step(4, 4'(i + 1));
    wait_done(4'd4);

    // Continuous shift right, stopped mid-WAIT after 6 steps.
    exp_q.push_back(4'b0111); exp_q.push_back(4'b0011); exp_q.push_back(4'b0001);
    for (int i = 0; i < 3; i++) exp_q.push_back(4'b0000);
    start_seq(2'b00, 4'b1111, 4'd0);
    for (int i = 0; i < 6; i++) wait_step(4, 4'(i + 1));
    cyc();
    cyc();
    stop = 1'b1;
    wait_done(4'd6);
    stop = 1'b0;
    repeat (6) cyc();

    // Continuous run to step_cnt wrap, stopped during the 16th STEP cycle.
    exp_q.push_back(4'b0100); exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
    for (int i = 0; i < 13; i++) exp_q.push_back(4'b0000);
    start_seq(2'b00, 4'b1000, 4'd0);
    for (int i = 0; i < 16; i++) wait_step(4, 4'(i + 1));
    stop = 1'b1;
    wait_done(4'd0);
    stop = 1'b0;

    // Stop during LOAD: no step at all.
    start_seq(2'b01, 4'b0011, 4'd5);
    stop = 1'b1;
    wait_done(4'd0);
    stop = 1'b0;
    repeat (6) cyc();

    // Asynchronous reset during WAIT; nothing resumes afterwards.
    start_seq(2'b01, 4'b0001, 4'd3);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("arst_ctrl", 32'(ctrl), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    step_pending = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (8) cyc();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ctrl", 32'(ctrl), 32'd0);
    chk("post_rst_step_cnt", 32'(step_cnt), 32'd0);

    // TICK_DIV = 1: LOAD, STEP, STEP, DONE back to back.
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    chk("t1_load", 32'(ctrl1), 32'h0000_00C2);
    cyc();
    chk("t1_step1", 32'(ctrl1), 32'h0000_0080);
    chk("t1_cnt1", 32'(step_cnt1), 32'd1);
    chk("t1_q_seed", 32'(reg_q1), 32'b0001);
    cyc();
    chk("t1_step2", 32'(ctrl1), 32'h0000_0080);
    chk("t1_cnt2", 32'(step_cnt1), 32'd2);
    cyc();
    chk("t1_done", 32'(done1), 32'd1);
    chk("t1_done_ctrl", 32'(ctrl1), 32'd0);
    chk("t1_q_final", 32'(reg_q1), 32'b0100);
    cyc();
    chk("t1_busy_fall", 32'(busy1), 32'd0);

    // Mode 11.
`ifdef SEQ_BOUNCE_EN
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
    start_seq(2'b11, 4'b0001, 4'd6);
    for (int i = 0; i < 6; i++) wait_step(4, 4'(i + 1));
    wait_done(4'd6);
`else
    exp_q.push_back(4'b0011); exp_q.push_back(4'b0110); exp_q.push_back(4'b1100);
    start_seq(2'b11, 4'b1001, 4'd3);
    for (int i = 0; i < 3; i++) wait_step(4, 4'(i + 1));
    wait_done(4'd3);
`endif

    repeat (2) cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
